// File: rtl/rv32_mem_access_if.sv
// Data-bus interface between the RV32 memory stage (master) and data memory (slave).
// Signal names keep the stage-side direction suffixes so both ends read the same.
interface rv32_mem_access_if;
    logic [31:0] data_address_out;
    logic        data_read_out;
    logic        data_write_out;
    logic [3:0]  data_write_mask_out;
    logic [31:0] data_write_value_out;
    logic [31:0] data_read_value_in;
    logic        data_ready_in;

    modport master (
        output data_address_out,
        output data_read_out,
        output data_write_out,
        output data_write_mask_out,
        output data_write_value_out,
        input  data_read_value_in,
        input  data_ready_in
    );

    modport slave (
        input  data_address_out,
        input  data_read_out,
        input  data_write_out,
        input  data_write_mask_out,
        input  data_write_value_out,
        output data_read_value_in,
        output data_ready_in
    );
endinterface

// File: rtl/rv32_mem_access.sv
// RV32 memory stage: data-bus load/store with ready handshake, load alignment, MEM/WB register.
// Define RV32_MISALIGN_TRAP_EN to trap misaligned accesses instead of force-aligning them.
module rv32_mem_access (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall_in,
    input  logic              flush_in,
    input  logic              valid_in,
    input  logic [4:0]        rd_in,
    input  logic              rd_write_in,
    input  logic              mem_read_in,
    input  logic              mem_write_in,
    input  logic [1:0]        mem_width_in,
    input  logic              mem_zero_extend_in,
    input  logic [31:0]       result_in,
    input  logic [31:0]       rs2_value_in,
    rv32_mem_access_if.master bus,
    output logic              mem_stall_out,
    output logic              valid_out,
    output logic [4:0]        rd_out,
    output logic              rd_write_out,
    output logic [31:0]       rd_value_out,
    output logic              trap_out
);

    typedef enum logic [0:0] {StIdle, StWait} state_e;

    state_e      state_q, state_d;
    logic        in_wait, capture;
    logic        mem_op, misalign, req, trap_now;

    // Access held on IDLE->WAIT so the bus stays stable regardless of upstream changes.
    logic [31:0] pend_result_q, pend_rs2_q;
    logic [4:0]  pend_rd_q;
    logic [1:0]  pend_width_q;
    logic        pend_rd_write_q, pend_read_q, pend_write_q, pend_zext_q, pend_flushed_q;

    logic [31:0] cur_result, cur_rs2;
    logic [4:0]  cur_rd;
    logic [1:0]  cur_width, offset;
    logic        cur_rd_write, cur_read, cur_write, cur_zext, cur_valid, cur_access;

    logic [3:0]  lane_mask;
    logic [31:0] lane_data, load_data;
    logic [7:0]  load_byte;
    logic [15:0] load_half;

    logic        wb_valid_q, wb_rd_write_q;
    logic [4:0]  wb_rd_q;
    logic [31:0] wb_value_q;

    assign in_wait = (state_q == StWait);
    assign mem_op  = valid_in & ~flush_in & (mem_read_in | mem_write_in);

`ifdef RV32_MISALIGN_TRAP_EN
    assign misalign = ((mem_width_in == 2'd1) & result_in[0]) |
                      (mem_width_in[1] & (result_in[1:0] != 2'b00));
`else
    assign misalign = 1'b0;
`endif

    assign req      = mem_op & ~misalign;
    assign trap_now = ~in_wait & mem_op & misalign;

    always_comb begin
        cur_result   = result_in;
        cur_rs2      = rs2_value_in;
        cur_rd       = rd_in;
        cur_rd_write = rd_write_in;
        cur_read     = mem_read_in;
        cur_write    = mem_write_in & ~mem_read_in;
        cur_width    = mem_width_in;
        cur_zext     = mem_zero_extend_in;
        cur_valid    = valid_in & ~flush_in & ~trap_now;
        cur_access   = req;
        if (in_wait) begin
            cur_result   = pend_result_q;
            cur_rs2      = pend_rs2_q;
            cur_rd       = pend_rd_q;
            cur_rd_write = pend_rd_write_q;
            cur_read     = pend_read_q;
            cur_write    = pend_write_q;
            cur_width    = pend_width_q;
            cur_zext     = pend_zext_q;
            // The bus access cannot be aborted, only its writeback squashed.
            cur_valid    = ~pend_flushed_q & ~flush_in;
            cur_access   = 1'b1;
        end
    end

    assign offset = cur_result[1:0];

    always_comb begin
        lane_mask = 4'b1111;
        lane_data = cur_rs2;
        case (cur_width)
            2'd0: begin
                lane_mask = 4'b0001 << offset;
                lane_data = {4{cur_rs2[7:0]}};
            end
            2'd1: begin
                lane_mask = offset[1] ? 4'b1100 : 4'b0011;
                lane_data = {2{cur_rs2[15:0]}};
            end
            default: begin
                lane_mask = 4'b1111;
                lane_data = cur_rs2;
            end
        endcase
    end

    always_comb begin
        load_byte = bus.data_read_value_in[{offset, 3'b000} +: 8];
        load_half = offset[1] ? bus.data_read_value_in[31:16] : bus.data_read_value_in[15:0];
        load_data = bus.data_read_value_in;
        case (cur_width)
            2'd0:    load_data = cur_zext ? {24'h0, load_byte}
                                          : {{24{load_byte[7]}}, load_byte};
            2'd1:    load_data = cur_zext ? {16'h0, load_half}
                                          : {{16{load_half[15]}}, load_half};
            default: load_data = bus.data_read_value_in;
        endcase
    end

    assign bus.data_address_out     = cur_access ? {cur_result[31:2], 2'b00} : 32'h0;
    assign bus.data_read_out        = cur_access & cur_read;
    assign bus.data_write_out       = cur_access & cur_write;
    assign bus.data_write_mask_out  = (cur_access & cur_write) ? lane_mask : 4'b0000;
    assign bus.data_write_value_out = (cur_access & cur_write) ? lane_data : 32'h0;

    assign mem_stall_out = cur_access & ~bus.data_ready_in;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (req && !bus.data_ready_in) state_d = StWait;
            StWait: if (bus.data_ready_in) state_d = StIdle;
            default: state_d = StIdle;
        endcase
        capture = (state_q == StIdle) && (state_d == StWait);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= StIdle;
            pend_result_q   <= 32'h0;
            pend_rs2_q      <= 32'h0;
            pend_rd_q       <= 5'h0;
            pend_width_q    <= 2'h0;
            pend_rd_write_q <= 1'b0;
            pend_read_q     <= 1'b0;
            pend_write_q    <= 1'b0;
            pend_zext_q     <= 1'b0;
            pend_flushed_q  <= 1'b0;
            wb_valid_q      <= 1'b0;
            wb_rd_q         <= 5'h0;
            wb_rd_write_q   <= 1'b0;
            wb_value_q      <= 32'h0;
        end else begin
            state_q <= state_d;
            if (capture) begin
                pend_result_q   <= result_in;
                pend_rs2_q      <= rs2_value_in;
                pend_rd_q       <= rd_in;
                pend_width_q    <= mem_width_in;
                pend_rd_write_q <= rd_write_in;
                pend_read_q     <= mem_read_in;
                pend_write_q    <= mem_write_in & ~mem_read_in;
                pend_zext_q     <= mem_zero_extend_in;
                pend_flushed_q  <= 1'b0;
            end else if (in_wait && flush_in) begin
                pend_flushed_q  <= 1'b1;
            end
            if (!stall_in) begin
                if (mem_stall_out) begin
                    wb_valid_q    <= 1'b0;
                    wb_rd_write_q <= 1'b0;
                end else begin
                    wb_valid_q    <= cur_valid;
                    wb_rd_q       <= cur_rd;
                    wb_rd_write_q <= cur_rd_write & cur_valid;
                    wb_value_q    <= cur_read ? load_data : cur_result;
                end
            end
        end
    end

`ifdef RV32_MISALIGN_TRAP_EN
    logic trap_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            trap_q <= 1'b0;
        end else if (!stall_in) begin
            trap_q <= mem_stall_out ? 1'b0 : trap_now;
        end
    end

    assign trap_out = trap_q;
`else
    assign trap_out = 1'b0;
`endif

    assign valid_out    = wb_valid_q;
    assign rd_out       = wb_rd_q;
    assign rd_write_out = wb_rd_write_q;
    assign rd_value_out = wb_value_q;

endmodule

// File: doc/rv32_mem_access.md
Name: rv32_mem_access

Overview:
- Memory stage of the RV32 pipeline.
- Sits between the EX/MEM pipeline register and the writeback stage.
- Performs load/store accesses on the data bus with a ready handshake, aligns and extends load data, and selects the rd result.
- Registers the MEM/WB outputs that feed writeback's valid/rd/rd_write/rd_value inputs, and stalls the pipeline while a bus access is outstanding.

Parameters:
- None. The datapath is fixed at 32 bits.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- stall_in  in  1  hazard stall; hold MEM/WB registers
- flush_in  in  1  hazard flush; squash current instruction
- valid_in  in  1  instruction present from EX/MEM
- rd_in  in  5  destination register
- rd_write_in  in  1  instruction writes rd
- mem_read_in  in  1  load
- mem_write_in  in  1  store
- mem_width_in  in  2  0=byte, 1=half, 2=word (3 treated as word)
- mem_zero_extend_in  in  1  zero- (1) vs sign- (0) extend loads
- result_in  in  32  ALU result / effective address
- rs2_value_in  in  32  store data
- data_address_out  out  32  bus address, word aligned ([1:0]=0)
- data_read_out  out  1  bus read strobe
- data_write_out  out  1  bus write strobe
- data_write_mask_out  out  4  byte-lane write enables
- data_write_value_out  out  32  lane-replicated store data
- data_read_value_in  in  32  bus read data
- data_ready_in  in  1  bus completes access this cycle
- mem_stall_out  out  1  to hazard unit: access pending
- valid_out  out  1  to writeback
- rd_out  out  5  to writeback
- rd_write_out  out  1  to writeback
- rd_value_out  out  32  to writeback
- trap_out  out  1  misaligned trap (optional feature only)

Behaviour:
- Clock and reset: one clock `clk`; `reset` is synchronous and active-high.
- Reset values: all registered outputs are 0 (valid_out, rd_out, rd_write_out, rd_value_out, trap_out); FSM goes to IDLE.
- FSM states:
  - IDLE. Access request = valid_in & !flush_in & (mem_read_in | mem_write_in). On a request, drive the bus combinationally in the same cycle.
    - data_ready_in=1: complete with zero extra latency; stay IDLE.
    - data_ready_in=0: go to WAIT.
  - WAIT. Bus address, strobes, mask and data are held from internal registers captured on IDLE->WAIT and stay stable until data_ready_in. On data_ready_in, go to IDLE.
- mem_stall_out = (IDLE & request & !data_ready_in) | (WAIT & !data_ready_in). It is combinational.
- Strobes: data_read_out/data_write_out = 0 whenever no access is in progress. Never assert both.
- Store lanes (offset = result_in[1:0]):
  - byte: mask = 1<<offset; data = {4{rs2[7:0]}}
  - half: mask = 4'b0011<<(offset[1]*2); data = {2{rs2[15:0]}}
  - word: mask = 4'b1111; data = rs2
- Load lanes: select the byte/half by offset, then sign- or zero-extend to 32 bits. Word passes through.
- rd select: a load produces the aligned load data. Any other instruction produces result_in.
- MEM/WB register, updated when !stall_in & !mem_stall_out:
  - valid_out <= valid_in & !flush_in
  - rd_out, rd_write_out, rd_value_out captured from the current instruction
- While mem_stall_out=1 (and !stall_in), insert a bubble: valid_out <= 0, rd_write_out <= 0.
- stall_in=1 with mem_stall_out=0: hold all MEM/WB registers.
- Boundary conditions:
  - flush_in during WAIT: the bus access cannot be aborted. Strobes are held until data_ready_in, then the completing instruction is written to MEM/WB with valid_out=0, rd_write_out=0.
  - reset mid-WAIT: next cycle the FSM is IDLE, strobes are 0 and the pending access is dropped.
  - Store: rd_write_out is passed through as given, normally 0.

Optional Feature:
- Macro: RV32_MISALIGN_TRAP_EN
- Defined:
  - Misaligned = half with offset[0]=1, or word with offset!=0.
  - A misaligned access issues no bus strobes and no stall.
  - MEM/WB captures trap_out=1, rd_write_out=0, valid_out=0.
  - trap_out is 0 for every other instruction.
- Undefined:
  - trap_out is tied 0.
  - Misaligned offsets are force-aligned: half uses offset[1] only; word ignores offset.
  - The access proceeds normally.

Test Plan:
- LB at 0x1003, bus word 0x80FF_1234, ready same cycle -> data_read_out=1, address 0x1000, no stall; next cycle rd_value_out=0xFFFF_FF80, valid_out=1.
- LHU at 0x2002, bus 0xBEEF_0000, ready after 3 cycles -> mem_stall_out=1 for 3 cycles with address/strobe stable; bubbles on valid_out; then rd_value_out=0x0000_BEEF.
- SB 0xAB at 0x3001, ready immediately -> data_write_mask_out=4'b0010, data_write_value_out=0xABAB_ABAB, valid_out=1, rd_write_out=0.
- ALU op result_in=0x1234_5678, rd=5 -> no bus strobes; rd_value_out=0x1234_5678, rd_out=5, rd_write_out=1 one cycle later.
- LW in WAIT; flush_in pulsed; ready 2 cycles later -> strobe held until ready, then valid_out=0; reset asserted instead mid-WAIT -> strobe 0 next cycle, all outputs 0.
- With RV32_MISALIGN_TRAP_EN: LW at 0x4002 -> no strobe, no stall, trap_out=1, rd_write_out=0. Without the macro: address 0x4000, normal word load.
